// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with a REQ/WAIT/HOLD handshake FSM.
// It issues instruction-memory reads, captures returned words into the
// IF/ID-facing registers, follows redirects and flags over-long memory waits.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds a sticky 'misalign'
// output for redirect targets whose bits [1:0] are nonzero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic        valid_out,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        misalign,
`endif
   output logic        timeout
);

   // Counter is wide enough to hold WAIT_MAX + 1 so "more than WAIT_MAX" is
   // representable; it never goes below 4 bits.
   localparam int CW = ($clog2(WAIT_MAX + 2) > 4) ? $clog2(WAIT_MAX + 2) : 4;
   localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);
   localparam logic [CW-1:0] CNT_SAT  = '1;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t         state;
   logic [31:0]    pc;
   logic [CW-1:0]  wait_cnt;
   logic [CW-1:0]  wait_base;
   logic [CW-1:0]  wait_inc;
   logic [31:0]    redirect_tgt;

   // The request is a pure decode of state, forced low while reset is held.
   assign imem_req  = ~reset & (state != ST_HOLD);
   assign imem_addr = pc;

   // Next wait count: a fresh request (REQ) starts from zero, WAIT continues;
   // the count saturates rather than wrapping.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      wait_base = '0;
      wait_inc  = '0;
      if (state == ST_WAIT) begin
         wait_base = wait_cnt;
      end
      wait_inc = (wait_base == CNT_SAT) ? wait_base : wait_base + CW'(1);
   end

   // Redirect targets are always word aligned; the low bits are dropped.
   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

   // Fetch FSM together with all of its registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (reset) begin
         state     <= ST_REQ;
         pc        <= RESET_PC;
         pc_out    <= '0;
         instr_out <= '0;
         valid_out <= 1'b0;
         timeout   <= 1'b0;
         wait_cnt  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign  <= 1'b0;
`endif
      end else if (redirect) begin
         // Redirect wins over stall and discards any same-cycle response.
         state     <= ST_REQ;
         pc        <= redirect_tgt;
         valid_out <= 1'b0;
         wait_cnt  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign  <= |redirect_pc[1:0];
`endif
      end else begin
         case (state)
            ST_REQ, ST_WAIT: begin
               if (imem_ready) begin
                  instr_out <= imem_rdata;
                  pc_out    <= pc + 32'd4;
                  valid_out <= 1'b1;
                  wait_cnt  <= '0;
                  if (stall) begin
                     // pc stays on the fetched word; it advances on leaving HOLD.
                     state <= ST_HOLD;
                  end else begin
                     pc    <= pc + 32'd4;
                     state <= ST_REQ;
                  end
               end else begin
                  state    <= ST_WAIT;
                  wait_cnt <= wait_inc;
                  if (wait_inc > WAIT_LIM) begin
                     timeout <= 1'b1;
                  end
                  // A stalled consumer still holds the previous instruction.
                  if (!stall) begin
                     valid_out <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  pc        <= pc + 32'd4;
                  state     <= ST_REQ;
                  valid_out <= 1'b0;
               end
            end
            default: begin
               state <= ST_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven bench for fetch_stage with a capture scoreboard.
// Each table row drives one clock cycle and states the expected request,
// address, valid and timeout; captured words are predicted into a queue and
// popped after the capturing edge. Reset sequences are hand written.
module tb_fetch_stage;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        valid_out;
   logic        timeout;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign;
`endif

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .WAIT_MAX (15)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .pc_out      (pc_out),
      .instr_out   (instr_out),
      .valid_out   (valid_out),
`ifdef FETCH_ALIGN_CHECK_EN
      .misalign    (misalign),
`endif
      .timeout     (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic        exp_to;
      logic        exp_mis;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } cap_t;

   vec_t        vecs[$];
   cap_t        exp_q[$];
   int          n_cmp;
   int          n_err;
   logic [31:0] last_pc;
   logic [31:0] last_instr;

   // Instruction memory contents: distinct from the address so pc_out and
   // instr_out cannot be confused.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                               input logic rdy, input logic er, input logic [31:0] ea,
                               input logic ev, input logic et, input logic em);
      vec_t v;
      v.stall = s;  v.redirect = r;  v.rpc = rpc;  v.ready = rdy;
      v.exp_req = er;  v.exp_addr = ea;  v.exp_valid = ev;
      v.exp_to = et;  v.exp_mis = em;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One table row = one clock cycle: drive at negedge, check the request,
   // then check registered outputs just after the rising edge.
   task automatic apply(input int idx, input vec_t v);
      cap_t c;
      @(negedge clock);
      stall       = v.stall;
      redirect    = v.redirect;
      redirect_pc = v.rpc;
      imem_ready  = v.ready;
      imem_rdata  = mem(v.exp_addr);
      #1;
      check($sformatf("row%0d imem_req", idx), {31'd0, imem_req}, {31'd0, v.exp_req});
      if (v.exp_req) begin
         check($sformatf("row%0d imem_addr", idx), imem_addr, v.exp_addr);
      end
      if (v.ready && v.exp_req && !v.redirect) begin
         c.pc    = v.exp_addr + 32'd4;
         c.instr = mem(v.exp_addr);
         exp_q.push_back(c);
      end
      @(posedge clock);
      #1;
      check($sformatf("row%0d valid_out", idx), {31'd0, valid_out}, {31'd0, v.exp_valid});
      check($sformatf("row%0d timeout", idx), {31'd0, timeout}, {31'd0, v.exp_to});
`ifdef FETCH_ALIGN_CHECK_EN
      check($sformatf("row%0d misalign", idx), {31'd0, misalign}, {31'd0, v.exp_mis});
`endif
      if (exp_q.size() != 0) begin
         c = exp_q.pop_front();
         last_pc    = c.pc;
         last_instr = c.instr;
      end
      check($sformatf("row%0d pc_out", idx), pc_out, last_pc);
      check($sformatf("row%0d instr_out", idx), instr_out, last_instr);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
      check({tag, " pc_out"}, pc_out, 32'd0);
      check({tag, " instr_out"}, instr_out, 32'd0);
      check({tag, " valid_out"}, {31'd0, valid_out}, 32'd0);
      check({tag, " timeout"}, {31'd0, timeout}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      check({tag, " misalign"}, {31'd0, misalign}, 32'd0);
`endif
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      last_pc     = '0;
      last_instr  = '0;
      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ready  = 1'b0;
      imem_rdata  = '0;

      // Stimulus table: (stall, redirect, redirect_pc, ready,
      //                  exp_req, exp_addr, exp_valid, exp_timeout, exp_misalign)
      // Back-to-back fetches, then a fetch of 0x8 with stall held three cycles.
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,  1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4,  1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 1, 32'h8,  1, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 32'h8, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h8,  0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'hC,  1, 0, 0));
      // Response at 0x10 delayed five cycles: address stable for six.
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 32'h10, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h14, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h18, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h1C, 1, 0, 0));
      // Redirect to 0x400 while waiting at 0x20 with a same-cycle response.
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h20, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h400, 1, 1, 32'h20, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h400, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h400, 1, 0, 0));
      // Response withheld 16 cycles: flag only on the 16th, then sticky.
      for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 32'h404, 0, (i == 15), 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h404, 1, 1, 0));
      // Misaligned redirect target 0x402 fetches from 0x400.
      vecs.push_back(mk(0, 1, 32'h402, 0, 1, 32'h408, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h400, 1, 1, 1));
      // Redirect to the top word; pc_out wraps to zero.
      vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h404, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0, 1, 1, 0));
      // Redirect and stall together: redirect wins.
      vecs.push_back(mk(1, 1, 32'h100, 1, 1, 32'h4, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100, 1, 1, 0));
      // Stalled miss keeps valid, unstalled miss clears it.
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h104, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h104, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 32'h104, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h108, 0, 1, 0));

      // Reset state while reset is held.
      repeat (3) @(posedge clock);
      #1;
      check_reset_state("reset");
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(i, vecs[i]);
      end

      // Asynchronous reset in the middle of a WAIT, away from any clock edge.
      @(negedge clock);
      imem_ready = 1'b0;
      stall      = 1'b0;
      redirect   = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("async_reset");
      exp_q.delete();
      last_pc    = '0;
      last_instr = '0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      apply(100, mk(0, 0, 0, 1, 1, 32'h0, 1, 0, 0));
      apply(101, mk(0, 0, 0, 1, 1, 32'h4, 1, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first instruction address after reset.
REQ-002 Parameter WAIT_MAX, default 15, SHALL be the memory wait-cycle limit before the timeout flag is raised.
REQ-003 clock  input  1  SHALL be the single clock, all state on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 stall  input  1  SHALL be high when the IF/ID register cannot accept a new instruction.
REQ-006 redirect  input  1  SHALL be the one-cycle branch/jump taken pulse from later stages.
REQ-007 redirect_pc  input  32  SHALL be the target address qualified by redirect.
REQ-008 imem_req  output  1  SHALL request an instruction-memory read.
REQ-009 imem_addr  output  32  SHALL be the read address, valid while imem_req is high.
REQ-010 imem_ready  input  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-011 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-012 pc_out  output  32  SHALL be fetched address + 4, feeding IF/ID pc_in.
REQ-013 instr_out  output  32  SHALL be the fetched word, feeding IF/ID instr_in.
REQ-014 valid_out  output  1  SHALL be high when pc_out/instr_out hold a live instruction.
REQ-015 timeout  output  1  SHALL be a sticky flag set when a request waits more than WAIT_MAX cycles.

Function
REQ-016 FSM states SHALL be REQ, WAIT, HOLD; reset state REQ.
REQ-017 REQ: imem_req=1, imem_addr=pc; imem_ready same cycle -> capture, go HOLD if stall else remain REQ with pc+=4; no imem_ready -> WAIT.
REQ-018 WAIT: imem_req held 1, address held stable; imem_ready -> capture and behave as REQ completion.
REQ-019 Capture SHALL register instr_out<=imem_rdata, pc_out<=pc+4, valid_out<=1, one cycle after imem_ready (latency 1).
REQ-020 HOLD: imem_req=0, outputs frozen while stall=1; stall low -> pc+=4, go REQ.
REQ-021 Cycle without capture and without stall SHALL drive valid_out=0; outputs hold last values.
REQ-022 redirect=1 in any state SHALL set pc<=redirect_pc, valid_out<=0, state<=REQ, next cycle.
REQ-023 redirect during WAIT SHALL discard the in-flight response: a same-cycle imem_ready is ignored; next request issues at redirect_pc.
REQ-024 redirect and stall together SHALL give redirect priority.
REQ-025 Wait counter (4+ bits, saturating) SHALL clear on each new request and increment per WAIT cycle; exceeding WAIT_MAX sets timeout, cleared only by reset.
REQ-026 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.

Reset
REQ-027 reset SHALL asynchronously force pc=RESET_PC, state=REQ, pc_out=0, instr_out=0, valid_out=0, timeout=0, wait counter=0.
REQ-028 reset mid-WAIT SHALL abandon the request; first post-reset request SHALL be RESET_PC.
REQ-029 imem_req SHALL be 0 while reset is asserted.

Configuration
REQ-030 With FETCH_ALIGN_CHECK_EN defined, a redirect_pc with bits [1:0] nonzero SHALL add output misalign (1 bit, sticky until next valid redirect or reset) and the target SHALL be used with bits [1:0] cleared.
REQ-031 Without FETCH_ALIGN_CHECK_EN, the misalign port SHALL be absent and redirect_pc[1:0] SHALL be silently forced to 0.

Verification
REQ-032 Release reset, imem_ready always 1, rdata=addr -> imem_addr 0,4,8; pc_out 4,8,C with valid_out=1 each cycle.
REQ-033 stall=1 for 3 cycles after fetch of 0x8 -> imem_req=0, pc_out=0xC and instr_out held; next request 0xC after stall drops.
REQ-034 imem_ready delayed 5 cycles at 0x10 -> imem_addr stable at 0x10 for 6 cycles, valid_out=0 until capture, timeout=0.
REQ-035 redirect to 0x400 while waiting at 0x20, imem_ready same cycle -> response dropped, next imem_addr=0x400, valid_out=0 that cycle.
REQ-036 imem_ready withheld 16 cycles -> timeout=1 and stays 1 after completion until reset.
REQ-037 With FETCH_ALIGN_CHECK_EN, redirect_pc=0x402 -> misalign=1, imem_addr=0x400; without it, imem_addr=0x400, no flag.
